// File: rtl/seq_mul_if.sv
// Handshake bundle for seq_mul: operand request (start/in_ready) and result return (out_valid/out_ready).
// The sgn line exists only when SEQ_MUL_SIGNED_EN is defined.
interface seq_mul_if #(
  parameter int W = 6
);
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
`ifdef SEQ_MUL_SIGNED_EN
  logic           sgn;
`endif
  logic           in_ready;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;
  logic           ovf;
  logic           busy;

`ifdef SEQ_MUL_SIGNED_EN
  modport master (output start, a, b, sgn, out_ready,
                  input  in_ready, out_valid, product, ovf, busy);
  modport slave  (input  start, a, b, sgn, out_ready,
                  output in_ready, out_valid, product, ovf, busy);
`else
  modport master (output start, a, b, out_ready,
                  input  in_ready, out_valid, product, ovf, busy);
  modport slave  (input  start, a, b, out_ready,
                  output in_ready, out_valid, product, ovf, busy);
`endif
endinterface

// File: rtl/seq_mul.sv
// seq_mul: W-bit iterative shift-add multiplier using a single 2W-bit adder, one step per cycle.
// Defining SEQ_MUL_SIGNED_EN adds the sgn input and two's-complement operation via magnitude and sign fix-up.
module seq_mul #(
  parameter int W = 6
) (
  input logic      clk,
  input logic      rst_n,
  seq_mul_if.slave bus
);

  localparam int PW = 2 * W;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] mcand_q, mcand_d;
  logic [W-1:0]  mplier_q, mplier_d;
  logic [PW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] product_q, product_d;
  logic          ovf_q, ovf_d;
  logic [PW-1:0] acc_sum;
  logic [PW-1:0] result;
  logic          result_ovf;
  logic [PW-1:0] cap_mcand;
  logic [W-1:0]  cap_mplier;

  function automatic logic ovf_unsigned(input logic [PW-1:0] p);
    return |p[PW-1:W];
  endfunction

  assign acc_sum = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

`ifdef SEQ_MUL_SIGNED_EN
  logic       sgn_q, sgn_d;
  logic       neg_q, neg_d;
  logic [W:0] a_ext, b_ext, a_mag, b_mag;

  function automatic logic ovf_signed(input logic [PW-1:0] p);
    return !((&p[PW-1:W-1]) || !(|p[PW-1:W-1]));
  endfunction

  // Operand magnitudes use one extra bit so -2^(W-1) negates without wrapping.
  always_comb begin
    a_ext = {bus.sgn & bus.a[W-1], bus.a};
    b_ext = {bus.sgn & bus.b[W-1], bus.b};
    if (a_ext[W]) begin
      a_mag = {(W+1){1'b0}} - a_ext;
    end else begin
      a_mag = a_ext;
    end
    if (b_ext[W]) begin
      b_mag = {(W+1){1'b0}} - b_ext;
    end else begin
      b_mag = b_ext;
    end
    cap_mcand  = PW'(a_mag);
    cap_mplier = W'(b_mag);
    if (neg_q) begin
      result = {PW{1'b0}} - acc_sum;
    end else begin
      result = acc_sum;
    end
    if (sgn_q) begin
      result_ovf = ovf_signed(result);
    end else begin
      result_ovf = ovf_unsigned(result);
    end
    if ((state_q == ST_IDLE) && bus.start) begin
      sgn_d = bus.sgn;
      neg_d = a_ext[W] ^ b_ext[W];
    end else begin
      sgn_d = sgn_q;
      neg_d = neg_q;
    end
  end

  // Sign mode and result sign captured with the operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sgn_q <= 1'b0;
      neg_q <= 1'b0;
    end else begin
      sgn_q <= sgn_d;
      neg_q <= neg_d;
    end
  end
`else
  always_comb begin
    cap_mcand  = PW'(bus.a);
    cap_mplier = bus.b;
    result     = acc_sum;
    result_ovf = ovf_unsigned(result);
  end
`endif

  // Next-state and datapath update; product/ovf only move on the final step.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    ovf_d     = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          mcand_d  = cap_mcand;
          mplier_d = cap_mplier;
          acc_d    = {PW{1'b0}};
          cnt_d    = {CW{1'b0}};
          state_d  = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1'b1;
        mplier_d = mplier_q >> 1'b1;
        cnt_d    = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        if (cnt_q == CW'(W - 1)) begin
          product_d = result;
          ovf_d     = result_ovf;
          state_d   = ST_DONE;
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mcand_q   <= {PW{1'b0}};
      mplier_q  <= {W{1'b0}};
      acc_q     <= {PW{1'b0}};
      cnt_q     <= {CW{1'b0}};
      product_q <= {PW{1'b0}};
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.busy      = (state_q == ST_BUSY);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.product   = product_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_seq_mul.sv
// Bench for seq_mul: directed W=6 scenarios plus random sweeps at W=1,8,16, checked by per-instance scoreboards.
module tb_seq_mul;

  typedef struct {
    logic [63:0]     p;
    bit              o;
    bit              s;
    longint unsigned iss;
  } exp_t;

  logic            clk      = 1'b0;
  logic            rst_n    = 1'b0;
  logic            rst_sw_n = 1'b0;
  int              checks   = 0;
  int              errors   = 0;
  longint unsigned cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 64'd1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string why);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, why);
  endtask

  // Reference: true integer product of the operands, reduced to 2w bits.
  function automatic void model(input int w, input logic [31:0] a, input logic [31:0] b,
                                input bit s, output logic [63:0] p, output bit o);
    longint sa, sb, r;
    sa = longint'(a);
    sb = longint'(b);
    if (s && a[w-1]) sa = sa - (64'sd1 <<< w);
    if (s && b[w-1]) sb = sb - (64'sd1 <<< w);
    r = sa * sb;
    p = 64'(r) & ((64'd1 << (2 * w)) - 64'd1);
    if (s) o = (r < -(64'sd1 <<< (w - 1))) || (r >= (64'sd1 <<< (w - 1)));
    else   o = (r >= (64'sd1 <<< w));
  endfunction

  // ---------------- W=6 instance: directed and random ----------------
  seq_mul_if #(.W(6)) m6 ();
  seq_mul #(.W(6)) u_dut6 (.clk(clk), .rst_n(rst_n), .bus(m6.slave));

  exp_t        q6[$];
  logic [11:0] held6;
  bit          seen6 = 1'b0;

  initial begin : mon6
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        seen6 = 1'b0;
      end else if (m6.out_valid) begin
        if (!seen6) begin
          seen6 = 1'b1;
          held6 = m6.product;
          if (q6.size() == 0) begin
            fail("w6_spurious", $sformatf("unexpected result 0x%0h", m6.product));
          end else begin
            e = q6.pop_front();
            chk($sformatf("w6_product(sgn=%0d)", e.s), 64'(m6.product), e.p);
            chk("w6_ovf", 64'(m6.ovf), 64'(e.o));
            chk("w6_latency", 64'(cyc - e.iss), 64'd7);
          end
        end else begin
          chk("w6_hold", 64'(m6.product), 64'(held6));
        end
      end else begin
        seen6 = 1'b0;
      end
    end
  end

  task automatic issue6(input logic [5:0] a, input logic [5:0] b, input bit s,
                        input logic [63:0] ep, input bit eo);
    int g = 0;
    @(negedge clk);
    while (!m6.in_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (!m6.in_ready) begin
      fail("w6_issue", "in_ready never returned");
    end else begin
      m6.a = a;
      m6.b = b;
`ifdef SEQ_MUL_SIGNED_EN
      m6.sgn = s;
`endif
      m6.start = 1'b1;
      q6.push_back('{p: ep, o: eo, s: s, iss: cyc});
      @(negedge clk);
      m6.start = 1'b0;
      m6.a = 6'($urandom);
      m6.b = 6'($urandom);
    end
  endtask

  task automatic drain6();
    int g = 0;
    m6.out_ready = 1'b1;
    while ((q6.size() != 0 || m6.out_valid) && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (q6.size() != 0 || m6.out_valid) fail("w6_drain", "result not delivered in time");
  endtask

  task automatic chk_reset6(input string tag);
    chk({tag, "_in_ready"},  64'(m6.in_ready),  64'd1);
    chk({tag, "_out_valid"}, 64'(m6.out_valid), 64'd0);
    chk({tag, "_busy"},      64'(m6.busy),      64'd0);
    chk({tag, "_product"},   64'(m6.product),   64'd0);
    chk({tag, "_ovf"},       64'(m6.ovf),       64'd0);
  endtask

  task automatic rand6(input int n_txn);
    int n = 0;
    int g = 0;
    logic [63:0] p;
    bit o, s;
    while (n < n_txn && g < 5000) begin
      @(negedge clk);
      g++;
      m6.start     = 1'b0;
      m6.a         = 6'($urandom);
      m6.b         = 6'($urandom);
      m6.out_ready = ($urandom_range(0, 3) != 0);
`ifdef SEQ_MUL_SIGNED_EN
      s = 1'($urandom_range(0, 1));
      m6.sgn = s;
`else
      s = 1'b0;
`endif
      if (m6.in_ready && $urandom_range(0, 1) == 1) begin
        model(6, 32'(m6.a), 32'(m6.b), s, p, o);
        q6.push_back('{p: p, o: o, s: s, iss: cyc});
        m6.start = 1'b1;
        n++;
      end
    end
    if (n < n_txn) fail("w6_random", "issue budget exhausted");
    @(negedge clk);
    m6.start = 1'b0;
    drain6();
  endtask

  // ---------------- parameter sweep: W = 1, 8, 16 ----------------
  for (genvar gi = 0; gi < 3; gi++) begin : g_sw
    localparam int WW = (gi == 0) ? 1 : ((gi == 1) ? 8 : 16);
    seq_mul_if #(.W(WW)) bus ();
    seq_mul #(.W(WW)) u_dut (.clk(clk), .rst_n(rst_sw_n), .bus(bus.slave));

    exp_t            q[$];
    logic [2*WW-1:0] held;
    bit              seen = 1'b0;
    bit              done = 1'b0;

    function automatic logic [WW-1:0] pick();
      logic [WW-1:0] v;
      case ($urandom_range(0, 4))
        0:       v = {WW{1'b1}};
        1:       v = {1'b1, {(WW-1){1'b0}}} ;
        2:       v = {WW{1'b0}};
        default: v = WW'($urandom);
      endcase
      return v;
    endfunction

    initial begin : drv
      int n, g;
      logic [63:0] p;
      bit o, s;
      bus.start     = 1'b0;
      bus.a         = {WW{1'b0}};
      bus.b         = {WW{1'b0}};
      bus.out_ready = 1'b1;
`ifdef SEQ_MUL_SIGNED_EN
      bus.sgn = 1'b0;
`endif
      n = 0;
      g = 0;
      while (n < 30 && g < 5000) begin
        @(negedge clk);
        g++;
        bus.start     = 1'b0;
        bus.a         = pick();
        bus.b         = pick();
        bus.out_ready = ($urandom_range(0, 3) != 0);
`ifdef SEQ_MUL_SIGNED_EN
        s = 1'($urandom_range(0, 1));
        bus.sgn = s;
`else
        s = 1'b0;
`endif
        if (rst_sw_n && bus.in_ready && $urandom_range(0, 1) == 1) begin
          model(WW, 32'(bus.a), 32'(bus.b), s, p, o);
          q.push_back('{p: p, o: o, s: s, iss: cyc});
          bus.start = 1'b1;
          n++;
        end
      end
      if (n < 30) fail($sformatf("w%0d_random", WW), "issue budget exhausted");
      @(negedge clk);
      bus.start     = 1'b0;
      bus.out_ready = 1'b1;
      g = 0;
      while ((q.size() != 0 || bus.out_valid) && g < 300) begin
        @(negedge clk);
        g++;
      end
      if (q.size() != 0 || bus.out_valid) fail($sformatf("w%0d_drain", WW), "result not delivered in time");
      done = 1'b1;
    end

    initial begin : mon
      exp_t e;
      forever begin
        @(posedge clk);
        #1;
        if (!rst_sw_n) begin
          seen = 1'b0;
        end else if (bus.out_valid) begin
          if (!seen) begin
            seen = 1'b1;
            held = bus.product;
            if (q.size() == 0) begin
              fail($sformatf("w%0d_spurious", WW), $sformatf("unexpected result 0x%0h", bus.product));
            end else begin
              e = q.pop_front();
              chk($sformatf("w%0d_product(sgn=%0d)", WW, e.s), 64'(bus.product), e.p);
              chk($sformatf("w%0d_ovf", WW), 64'(bus.ovf), 64'(e.o));
              chk($sformatf("w%0d_latency", WW), 64'(cyc - e.iss), 64'(WW + 1));
            end
          end else begin
            chk($sformatf("w%0d_hold", WW), 64'(bus.product), 64'(held));
          end
        end else begin
          seen = 1'b0;
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin : main
    int g;
    m6.start     = 1'b0;
    m6.a         = 6'd0;
    m6.b         = 6'd0;
    m6.out_ready = 1'b0;
`ifdef SEQ_MUL_SIGNED_EN
    m6.sgn = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk_reset6("rst_held");
    rst_n    = 1'b1;
    rst_sw_n = 1'b1;
    @(negedge clk);
    chk_reset6("rst_released");

    m6.out_ready = 1'b1;
    issue6(6'd5,  6'd7,  1'b0, 64'h023, 1'b0);
    issue6(6'd63, 6'd63, 1'b0, 64'hF81, 1'b1);
    issue6(6'd0,  6'd63, 1'b0, 64'h000, 1'b0);
    drain6();

    // Back-pressure with start pulses in BUSY and DONE.
    m6.out_ready = 1'b0;
    issue6(6'd21, 6'd50, 1'b0, 64'h41A, 1'b1);
    m6.start = 1'b1;
    m6.a     = 6'd1;
    m6.b     = 6'd1;
    @(negedge clk);
    m6.start = 1'b0;
    g = 0;
    while (!m6.out_valid && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (!m6.out_valid) fail("bp_wait_valid", "out_valid never rose");
    for (int i = 0; i < 10; i++) begin
      m6.start = (i == 4);
      m6.a     = 6'd2;
      m6.b     = 6'd2;
      @(negedge clk);
      chk("bp_in_ready",  64'(m6.in_ready),  64'd0);
      chk("bp_out_valid", 64'(m6.out_valid), 64'd1);
    end
    m6.start     = 1'b0;
    m6.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_in_ready",  64'(m6.in_ready),  64'd1);
    chk("bp_release_out_valid", 64'(m6.out_valid), 64'd0);
    chk("bp_queue_empty",       64'(q6.size()),    64'd0);

    // Asynchronous reset in the third BUSY cycle.
    issue6(6'd63, 6'd63, 1'b0, 64'hF81, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("busy_before_reset", 64'(m6.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk_reset6("rst_busy");
    q6.delete();
    @(negedge clk);
    rst_n = 1'b1;
    issue6(6'd3, 6'd4, 1'b0, 64'd12, 1'b0);
    drain6();

`ifdef SEQ_MUL_SIGNED_EN
    issue6(6'h20, 6'h20, 1'b1, 64'h400, 1'b1);
    issue6(6'h3F, 6'd5,  1'b1, 64'hFFB, 1'b0);
    issue6(6'h20, 6'd1,  1'b1, 64'hFE0, 1'b0);
    issue6(6'd63, 6'd1,  1'b0, 64'd63,  1'b0);
    drain6();
`endif

    rand6(40);

    g = 0;
    while (!(g_sw[0].done && g_sw[1].done && g_sw[2].done) && g < 20000) begin
      @(negedge clk);
      g++;
    end
    if (!(g_sw[0].done && g_sw[1].done && g_sw[2].done)) fail("sweep_done", "width sweep did not complete");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_mul.md
# seq_mul

Parametrised iterative shift-add multiplier for the ALU datapath. It replaces the single-cycle 6x6 array multiplier with a W-bit multi-cycle unit that uses one adder. Operands are accepted on a start/ready handshake and the 2W-bit product is returned on a valid/ready handshake. It also reports whether the product fits in W bits, so ALU flag logic can use it directly.

## Interface
- W, 6: operand width, legal range 1..32; product width is 2W.
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; operands are captured when start=1 and in_ready=1.
- a  input  W  multiplicand.
- b  input  W  multiplier.
- sgn  input  1  two's-complement mode select; present only with SEQ_MUL_SIGNED_EN; sampled together with a and b.
- in_ready  output  1  unit idle, can accept start.
- out_valid  output  1  product and ovf valid.
- out_ready  input  1  consumer accepts the result.
- product  output  2W  result; held stable while out_valid=1.
- ovf  output  1  result does not fit in W bits.
- busy  output  1  unit is in BUSY.

## Operation
- FSM has three states: IDLE, BUSY and DONE. Reset enters IDLE.
- IDLE:
  - in_ready=1.
  - On start=1 the unit does all of the following and enters BUSY: latches a into mcand (2W), latches b into mplier (W), clears acc (2W) and clears cnt.
- BUSY, one step per cycle:
  - If mplier[0]=1, then acc <= acc + mcand, with the add done mod 2^2W.
  - mcand <= mcand << 1.
  - mplier <= mplier >> 1.
  - cnt <= cnt + 1.
  - When cnt = W-1, the step completes and the state goes to DONE.
  - cnt width is clog2(W+1).
- DONE:
  - out_valid=1.
  - product = acc.
  - ovf:
    - Unsigned: ovf = |acc[2W-1:W].
    - Signed: ovf = 1 when acc[2W-1:W-1] is not all 0s or all 1s.
  - On out_ready=1 the state goes to IDLE.
- start is ignored while in_ready=0. No queuing.
- a, b and sgn may change freely after capture without affecting the result.
- product and ovf keep their last value in IDLE and BUSY. They update only on the BUSY-to-DONE transition.
- Reset values: in_ready=1, out_valid=0, busy=0, product=0, ovf=0, and all internal registers 0.
- Asynchronous reset during BUSY or DONE aborts the operation and discards the result. The first cycle after reset release is IDLE.
- W=1: BUSY lasts exactly one cycle.

## Timing
- Capture edge is t0, which is the edge where start=1 and in_ready=1.
- BUSY is held for edges t1..tW. out_valid rises after edge tW, so the result is visible W+1 cycles after the start edge.
- in_ready drops in the cycle after t0 and returns the cycle after the out_valid/out_ready edge.
- Minimum issue interval is W+2 cycles, with out_ready held at 1.
- The output handshake is combinational-free: out_valid and product come from registers only. out_ready does not combinationally affect any output.
- If out_ready is held 0, DONE persists indefinitely with product stable.

## Configuration
- SEQ_MUL_SIGNED_EN defined:
  - The sgn port exists.
  - With sgn=1, both a and b are treated as two's complement. The unit captures |a| and |b| with an (W+1)-bit negation, so a = -2^(W-1) is handled. It records neg = a[W-1]^b[W-1] and runs the unsigned iteration.
  - On the BUSY-to-DONE transition, if neg=1, product = -acc (2W-bit two's complement). This adds no extra cycle.
  - ovf uses the signed rule.
  - With sgn=0, behaviour is identical to the unsigned build.
- SEQ_MUL_SIGNED_EN undefined:
  - No sgn port.
  - Unsigned only, unsigned ovf rule.
  - No sign or negation logic is synthesised.

## Test plan
- Reset, W=6: all outputs at reset values. Then start with a=5, b=7 → out_valid rises exactly 7 cycles after the start edge, product=35 (0x023), ovf=0.
- a=63, b=63 → product=3969 (0xF81), ovf=1. a=0, b=63 → product=0, ovf=0.
- Back-pressure:
  - Hold out_ready=0 for 10 cycles in DONE → product stays stable and in_ready stays 0.
  - Pulse start during BUSY and DONE → ignored.
  - Raise out_ready → IDLE, in_ready=1 the next cycle.
- Assert rst_n=0 at the third BUSY cycle → immediate reset values. A new start with a=3, b=4 then yields 12.
- SEQ_MUL_SIGNED_EN, sgn=1:
  - a=-32, b=-32 → product=1024 (0x400), ovf=1.
  - a=-1, b=5 → product=0xFFB, ovf=0.
  - a=-32, b=1 → 0xFE0, ovf=0.
  - sgn=0, a=63, b=1 → 63, ovf=0.
- Parameter sweep W=1, 8, 16 with random operands against the reference a*b. Check latency W+1 cycles on every transaction.
